// File: rtl/sm_regdump_uart_pkg.sv
// Shared types and constants for the register-dump UART.
// Optional build macro: SM_REGDUMP_PREFIX_EN adds an "AA=" address prefix to every line.
package sm_regdump_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SEND  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_EQ = 8'h3D;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

`ifdef SM_REGDUMP_PREFIX_EN
    localparam int PREFIX_CHARS = 3;
`else
    localparam int PREFIX_CHARS = 0;
`endif

    // prefix + 8 hex digits + CR + LF
    localparam int LINE_CHARS = PREFIX_CHARS + 10;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return ASCII_0 + {4'd0, n};
        end
        return ASCII_A + {4'd0, n - 4'd10};
    endfunction

endpackage

// File: rtl/sm_regdump_uart_if.sv
// Debug-port / control bundle between the dump engine (master) and the rest of the top level.
// Handshake: start is a one-cycle request honoured only while busy==0; done pulses once when the line goes idle.
interface sm_regdump_uart_if;
    import sm_regdump_uart_pkg::*;

    logic        start;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        busy;
    logic        done;
    logic        tx;
    state_t      dbg_state;

    modport master (
        input  start,
        input  regData,
        output regAddr,
        output busy,
        output done,
        output tx,
        output dbg_state
    );

    modport slave (
        output start,
        output regData,
        input  regAddr,
        input  busy,
        input  done,
        input  tx,
        input  dbg_state
    );

endinterface

// File: rtl/sm_uart_tx.sv
// 8N1 byte transmitter. A byte is taken on valid&ready; ready also rises on the last
// stop-bit clock so a waiting byte starts the next frame with no idle gap.
module sm_uart_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [3:0]    BIT_STOP  = 4'd9;

    logic          r_active;
    logic          r_tx;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [9:0]    r_shift;
    logic          w_bit_end;
    logic          w_take;

    assign w_bit_end = r_baud == BAUD_LAST;
    assign ready     = !r_active || (w_bit_end && r_bit == BIT_STOP);
    assign w_take    = valid && ready;
    assign tx        = r_tx;

    // r_shift[0] is the bit currently on the line; r_shift[1] is the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_tx     <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
        end else if (w_take) begin
            r_active <= 1'b1;
            r_tx     <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= {1'b1, data, 1'b0};
        end else if (r_active) begin
            if (w_bit_end) begin
                r_baud <= '0;
                if (r_bit == BIT_STOP) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                    r_bit    <= '0;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[1];
                    r_shift <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_baud <= r_baud + BW'(1);
            end
        end
    end

endmodule

// File: rtl/sm_regdump_uart.sv
// Walks the register-file debug port and sends each word as an ASCII hex line over UART.
// Build macro SM_REGDUMP_PREFIX_EN: prefix each line with the 2-digit address and '='.
module sm_regdump_uart
    import sm_regdump_uart_pkg::*;
#(
    parameter int CLK_DIV   = 434,
    parameter int REG_COUNT = 32
) (
    input  logic              clk,
    input  logic              rst,
    sm_regdump_uart_if.master bus
);

    localparam logic [4:0] LAST_ADDR   = 5'(REG_COUNT - 1);
    localparam logic [3:0] LAST_IDX    = 4'(LINE_CHARS - 1);
    localparam logic [3:0] CR_IDX      = 4'(LINE_CHARS - 2);
    localparam logic [3:0] FIRST_DIGIT = 4'(PREFIX_CHARS);

    state_t      r_state;
    state_t      w_state_nx;
    logic [4:0]  r_addr;
    logic [31:0] r_shadow;
    logic [3:0]  r_idx;

    logic        w_load;
    logic        w_tx_valid;
    logic        w_tx_ready;
    logic        w_tx;
    logic        w_take;
    logic        w_last_char;
    logic        w_last_addr;
    logic [2:0]  w_digit;
    logic [3:0]  w_nib;
    logic [7:0]  w_char;

    assign w_last_char = r_idx == LAST_IDX;
    assign w_last_addr = r_addr == LAST_ADDR;
    assign w_take      = w_tx_valid && w_tx_ready;

    // Digit 0 is the most significant nibble of the shadow word.
    assign w_digit = 3'(r_idx - FIRST_DIGIT);
    assign w_nib   = r_shadow[{3'd7 - w_digit, 2'b00} +: 4];

    always_comb begin
        w_char = hex_ascii(w_nib);
        if (r_idx == CR_IDX) begin
            w_char = ASCII_CR;
        end else if (r_idx == LAST_IDX) begin
            w_char = ASCII_LF;
        end
`ifdef SM_REGDUMP_PREFIX_EN
        else if (r_idx == 4'd0) begin
            w_char = hex_ascii({3'b000, r_addr[4]});
        end else if (r_idx == 4'd1) begin
            w_char = hex_ascii(r_addr[3:0]);
        end else if (r_idx == 4'd2) begin
            w_char = ASCII_EQ;
        end
`endif
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_tx_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nx = ST_ADDR;
                end
            end
            ST_ADDR: begin
                w_state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                w_load     = 1'b1;
                w_state_nx = ST_SEND;
            end
            ST_SEND: begin
                w_tx_valid = 1'b1;
                if (w_tx_ready && w_last_char) begin
                    w_state_nx = w_last_addr ? ST_DRAIN : ST_ADDR;
                end
            end
            // The last LF is still on the wire; done waits for its stop bit.
            ST_DRAIN: begin
                if (w_tx_ready) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_shadow <= '0;
            r_idx    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_load) begin
                r_shadow <= bus.regData;
                r_idx    <= '0;
            end
            if (w_take) begin
                if (w_last_char) begin
                    r_idx <= '0;
                    if (!w_last_addr) begin
                        r_addr <= r_addr + 5'd1;
                    end
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
            if (r_state == ST_DONE) begin
                r_addr <= '0;
            end
        end
    end

    sm_uart_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .data (w_char),
        .valid(w_tx_valid),
        .ready(w_tx_ready),
        .tx   (w_tx)
    );

    assign bus.regAddr   = r_addr;
    assign bus.busy      = r_state != ST_IDLE;
    assign bus.done      = r_state == ST_DONE;
    assign bus.tx        = w_tx;
    assign bus.dbg_state = r_state;

endmodule
